a23_wb_arbiter: RTL and testbench

Shares the single Wishbone slave bus (64 kB memory plus the 0x10000000 output port) between N masters. Master 0 is the a23_core; master 1 is the planned DMA/debug loader. Uses round-robin arbitration, with each grant locked for a whole Wishbone cycle (o_wb_cyc high). An optional watchdog terminates stalled transfers with an error.

---
 rtl/a23_wb_pkg.sv | 27 ++
 rtl/a23_wb_arbiter_rr_pick.sv | 35 +++
 rtl/a23_wb_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_a23_wb_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a23_wb_pkg.sv
// ----------------------------------------------------------------------------
// a23_wb_pkg
// Shared definitions for the a23 Wishbone arbiter slice:
//   - Wishbone field widths (address, data, byte select)
//   - arbiter FSM state encoding
//   - address of the memory-mapped output port
//   - rr_wrap(): modulo helper used for round-robin index arithmetic
// ----------------------------------------------------------------------------
package a23_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [WB_ADR_W-1:0] IO_PORT_ADR = 32'h1000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Wrap a master index into 0..n-1.
    function automatic int rr_wrap(input int idx, input int n);
        return idx % n;
    endfunction

endpackage

// File: rtl/a23_wb_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// a23_rr_pick
// Combinational round-robin priority picker. Starting at ptr_i and wrapping
// modulo N, the first set bit of req_i is granted.
//
// Ports:
//   req_i  [N-1:0]      request vector (one bit per master)
//   ptr_i  [PTR_W-1:0]  index of the highest-priority master this round
//   gnt_o  [N-1:0]      one-hot grant (all zero when nothing requests)
//   vld_o               at least one request was found
// ----------------------------------------------------------------------------
module a23_rr_pick
    import a23_wb_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic             vld_o
);

    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!vld_o && req_i[rr_wrap(int'(ptr_i) + i, N)]) begin
                gnt_o[rr_wrap(int'(ptr_i) + i, N)] = 1'b1;
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/a23_wb_arbiter.sv
// ----------------------------------------------------------------------------
// a23_wb_arbiter
// Shares one Wishbone slave bus (64 kB memory + output port) between
// N_MASTERS masters. Round-robin arbitration; a grant is held for the whole
// Wishbone cycle (until the granted master drops cyc).
//
// Optional feature (compile-time macro A23_WB_ARB_TIMEOUT_EN):
//   watchdog that answers a strobe stalled for TIMEOUT_CYCLES cycles with a
//   one-cycle error to the granted master and drops the slave strobe for
//   that cycle. Without the macro, err is a pure pass-through.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_m_adr/sel/we/dat        per-master request fields, master k in slice k
//   i_m_cyc, i_m_stb          per-master cycle / strobe
//   o_m_dat                   slave read data broadcast to all masters
//   o_m_ack, o_m_err          per-master acknowledge / error
//   o_wb_adr/sel/we/dat       slave-side request, muxed from granted master
//   o_wb_cyc, o_wb_stb        slave-side cycle / strobe
//   i_wb_dat, i_wb_ack, i_wb_err  slave response
// ----------------------------------------------------------------------------
module a23_wb_arbiter
    import a23_wb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [WB_ADR_W*N_MASTERS-1:0] i_m_adr,
    input  logic [WB_SEL_W*N_MASTERS-1:0] i_m_sel,
    input  logic [N_MASTERS-1:0]          i_m_we,
    input  logic [WB_DAT_W*N_MASTERS-1:0] i_m_dat,
    input  logic [N_MASTERS-1:0]          i_m_cyc,
    input  logic [N_MASTERS-1:0]          i_m_stb,
    output logic [WB_DAT_W-1:0]           o_m_dat,
    output logic [N_MASTERS-1:0]          o_m_ack,
    output logic [N_MASTERS-1:0]          o_m_err,
    output logic [WB_ADR_W-1:0]           o_wb_adr,
    output logic [WB_SEL_W-1:0]           o_wb_sel,
    output logic                          o_wb_we,
    output logic [WB_DAT_W-1:0]           o_wb_dat,
    output logic                          o_wb_cyc,
    output logic                          o_wb_stb,
    input  logic [WB_DAT_W-1:0]           i_wb_dat,
    input  logic                          i_wb_ack,
    input  logic                          i_wb_err
);

    localparam int PTR_W = $clog2(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 4) begin : g_bad_n_masters
        $error("a23_wb_arbiter: N_MASTERS must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("a23_wb_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]     gnt_q, gnt_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [N_MASTERS-1:0] pick_oh;
    logic                 pick_vld;
    logic [PTR_W-1:0]     pick_idx;
    logic                 g_cyc, g_stb;
    logic                 timeout;

    a23_rr_pick #(
        .N     (N_MASTERS),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i (i_m_cyc),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh),
        .vld_o (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (pick_oh[k]) pick_idx = PTR_W'(k);
        end
    end

    // Raw cyc/stb of the currently granted master (before any watchdog force).
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (gnt_q == PTR_W'(k)) begin
                g_cyc = i_m_cyc[k];
                g_stb = i_m_stb[k];
            end
        end
    end

`ifdef A23_WB_ARB_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;

    // Counts stalled strobe cycles; fires on the TIMEOUT_CYCLES-th one.
    always_comb begin
        timeout = (state_q == BUSY) && g_stb && !i_wb_ack && !i_wb_err &&
                  (wdog_q == 8'(TIMEOUT_CYCLES - 1));
        wdog_d  = wdog_q;
        if (state_q != BUSY || !g_cyc || i_wb_ack || i_wb_err || timeout) begin
            wdog_d = '0;
        end else if (g_stb) begin
            wdog_d = wdog_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) wdog_q <= '0;
        else       wdog_q <= wdog_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic. The grant is only re-evaluated in IDLE, so requests
    // from other masters cannot steal the bus mid-cycle.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                    gnt_d   = pick_idx;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    ptr_d   = PTR_W'(rr_wrap(int'(gnt_q) + 1, N_MASTERS));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: everything is zero outside BUSY; o_m_dat always follows
    // the slave.
    always_comb begin
        o_wb_adr = '0;
        o_wb_sel = '0;
        o_wb_we  = 1'b0;
        o_wb_dat = '0;
        o_wb_cyc = 1'b0;
        o_wb_stb = 1'b0;
        o_m_ack  = '0;
        o_m_err  = '0;
        o_m_dat  = i_wb_dat;
        if (state_q == BUSY) begin
            for (int k = 0; k < N_MASTERS; k++) begin
                if (gnt_q == PTR_W'(k)) begin
                    o_wb_adr   = i_m_adr[WB_ADR_W*k +: WB_ADR_W];
                    o_wb_sel   = i_m_sel[WB_SEL_W*k +: WB_SEL_W];
                    o_wb_we    = i_m_we[k];
                    o_wb_dat   = i_m_dat[WB_DAT_W*k +: WB_DAT_W];
                    o_wb_cyc   = i_m_cyc[k];
                    o_wb_stb   = i_m_stb[k] & ~timeout;
                    o_m_ack[k] = i_wb_ack;
                    o_m_err[k] = i_wb_err | timeout;
                end
            end
        end
    end

endmodule

// File: tb/tb_a23_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_a23_wb_arbiter
// Scoreboarded bench for a23_wb_arbiter (2 masters, TIMEOUT_CYCLES=8).
// Masters push each request into a per-master expectation queue; a monitor
// pops on every master acknowledge and compares the slave-side request and
// the returned read data against a reference memory. Directed sequences
// check arbitration order through the sequence of acknowledging masters.
// Build with +define+A23_WB_ARB_TIMEOUT_EN to exercise the watchdog.
// ----------------------------------------------------------------------------
module tb_a23_wb_arbiter;
    import a23_wb_pkg::*;

    localparam int NM = 2;
    localparam int TO = 8;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } req_t;

    logic            clk;
    logic            rst;
    logic [31:0]     m_adr [NM];
    logic [3:0]      m_sel [NM];
    logic [31:0]     m_dat [NM];
    logic [NM-1:0]   m_we, m_cyc, m_stb;

    logic [32*NM-1:0] i_m_adr;
    logic [4*NM-1:0]  i_m_sel;
    logic [32*NM-1:0] i_m_dat;
    logic [31:0]      o_m_dat;
    logic [NM-1:0]    o_m_ack, o_m_err;
    logic [31:0]      o_wb_adr, o_wb_dat;
    logic [3:0]       o_wb_sel;
    logic             o_wb_we, o_wb_cyc, o_wb_stb;
    logic [31:0]      s_dat;
    logic             s_ack;
    logic             s_err;
    int               s_wait;
    bit               stall;

    assign i_m_adr = {m_adr[1], m_adr[0]};
    assign i_m_sel = {m_sel[1], m_sel[0]};
    assign i_m_dat = {m_dat[1], m_dat[0]};

    a23_wb_arbiter #(
        .N_MASTERS      (NM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_m_adr  (i_m_adr),
        .i_m_sel  (i_m_sel),
        .i_m_we   (m_we),
        .i_m_dat  (i_m_dat),
        .i_m_cyc  (m_cyc),
        .i_m_stb  (m_stb),
        .o_m_dat  (o_m_dat),
        .o_m_ack  (o_m_ack),
        .o_m_err  (o_m_err),
        .o_wb_adr (o_wb_adr),
        .o_wb_sel (o_wb_sel),
        .o_wb_we  (o_wb_we),
        .o_wb_dat (o_wb_dat),
        .o_wb_cyc (o_wb_cyc),
        .o_wb_stb (o_wb_stb),
        .i_wb_dat (s_dat),
        .i_wb_ack (s_ack),
        .i_wb_err (s_err)
    );

    int   total = 0;
    int   bad   = 0;
    int   ack_code;
    int   gap_log[$];
    int   idle_run;
    req_t exp_q [NM][$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
    endfunction

    // Slave: registered ack after 0..2 wait cycles; never acks while stalled.
    initial begin
        s_ack  = 1'b0;
        s_err  = 1'b0;
        s_dat  = '0;
        s_wait = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                s_ack  <= 1'b0;
                s_wait <= 0;
            end else if (s_ack) begin
                s_ack <= 1'b0;
            end else if (o_wb_cyc && o_wb_stb && !stall) begin
                if (s_wait == 0) begin
                    s_ack <= 1'b1;
                    if (o_wb_we) slv_mem[o_wb_adr] = merge(slv_rd(o_wb_adr), o_wb_dat, o_wb_sel);
                    else         s_dat <= slv_rd(o_wb_adr);
                    s_wait <= $urandom_range(2, 0);
                end else begin
                    s_wait <= s_wait - 1;
                end
            end
        end
    end

    // Monitor: idle-gap log and scoreboard check on every master ack.
    initial begin
        int   m;
        req_t e;
        idle_run = 0;
        forever begin
            @(negedge clk);
            if (!o_wb_cyc) idle_run++;
            else if (idle_run != 0) begin
                gap_log.push_back(idle_run);
                idle_run = 0;
            end
            if (o_m_ack != '0) begin
                check("ack_onehot", 32'($countones(o_m_ack)), 32'd1);
                m = o_m_ack[1] ? 1 : 0;
                ack_code = ack_code * 10 + m + 1;
                if (exp_q[m].size() == 0) begin
                    check("sb_unexpected_ack", 32'(m + 1), 32'd0);
                end else begin
                    e = exp_q[m].pop_front();
                    check("wb_adr", o_wb_adr, e.adr);
                    check("wb_we", 32'(o_wb_we), 32'(e.we));
                    check("wb_sel", 32'(o_wb_sel), 32'(e.sel));
                    if (e.we) begin
                        check("wb_dat", o_wb_dat, e.dat);
                        ref_mem[e.adr] = merge(ref_rd(e.adr), e.dat, e.sel);
                    end else begin
                        check("rd_dat", o_m_dat, ref_rd(e.adr));
                    end
                end
            end
        end
    end

    task automatic run_cycle(input int m, input int nb, input logic [31:0] adr0,
                             input logic we, input logic [31:0] dat0,
                             input logic [3:0] sel, output int lat);
        req_t r;
        int   n;
        bit   got;
        lat = -1;
        @(posedge clk); #1;
        for (int b = 0; b < nb; b++) begin
            r.adr = adr0 + 32'(4 * b);
            r.sel = sel;
            r.we  = we;
            r.dat = dat0 + 32'(b);
            m_adr[m] = r.adr;
            m_sel[m] = r.sel;
            m_we[m]  = r.we;
            m_dat[m] = r.dat;
            m_cyc[m] = 1'b1;
            m_stb[m] = 1'b1;
            exp_q[m].push_back(r);
            got = 1'b0;
            n   = 0;
            while (!got && n < 300) begin
                @(negedge clk);
                if (lat < 0 && o_wb_cyc) lat = n;
                if (o_m_ack[m] || o_m_err[m]) got = 1'b1;
                n++;
            end
            if (!got) check("ack_wait", 32'(got), 32'd1);
            @(posedge clk); #1;
        end
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        m_we[m]  = 1'b0;
    endtask

    task automatic rand_cycle(input int m);
        int lat;
        run_cycle(m, $urandom_range(3, 1), $urandom & 32'h0000_FFF0,
                  1'($urandom_range(1, 0)), $urandom, 4'($urandom_range(15, 1)), lat);
    endtask

    initial begin
        int lat;
        int first, err_at, err_cnt;
        logic stb_at_err, err_after;

        rst   = 1'b1;
        stall = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        for (int k = 0; k < NM; k++) begin
            m_adr[k] = '0;
            m_sel[k] = '0;
            m_dat[k] = '0;
        end
        ack_code = 0;

        // Reset: a request during reset must not reach the slave.
        repeat (3) @(posedge clk);
        #1;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        m_adr[0] = 32'h0000_1234;
        m_dat[0] = 32'hA5A5_5A5A;
        m_sel[0] = 4'hF;
        repeat (2) @(negedge clk);
        check("rst_wb_cyc", 32'(o_wb_cyc), 32'd0);
        check("rst_wb_stb", 32'(o_wb_stb), 32'd0);
        check("rst_m_ack", 32'(o_m_ack), 32'd0);
        check("rst_m_err", 32'(o_m_err), 32'd0);
        check("rst_wb_adr", o_wb_adr, 32'd0);
        check("rst_wb_dat", o_wb_dat, 32'd0);
        m_cyc = '0;
        m_stb = '0;
        m_adr[0] = '0;
        m_dat[0] = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Master 0 single read: one-cycle arbitration latency.
        ack_code = 0;
        run_cycle(0, 1, 32'h0000_0010, 1'b0, 32'd0, 4'hF, lat);
        check("t1_latency", 32'(lat), 32'd1);
        check("t1_order", 32'(ack_code), 32'd1);

        // Reset mid-cycle drops cyc/stb without a clock edge.
        stall = 1'b1;
        @(posedge clk); #1;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        m_adr[1] = 32'h0000_0040;
        repeat (2) @(negedge clk);
        check("mr_granted", 32'(o_wb_cyc), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mr_cyc_drop", 32'(o_wb_cyc), 32'd0);
        check("mr_stb_drop", 32'(o_wb_stb), 32'd0);
        m_cyc = '0;
        m_stb = '0;
        @(posedge clk); #1;
        rst   = 1'b0;
        stall = 1'b0;

        // Simultaneous requests after reset: master 0 first, then master 1
        // after the released-cycle beat plus one IDLE cycle.
        ack_code = 0;
        gap_log.delete();
        fork
            run_cycle(0, 1, 32'h0000_0020, 1'b1, 32'h1111_0000, 4'hF, lat);
            begin
                int l1;
                run_cycle(1, 1, 32'h0000_0020, 1'b0, 32'd0, 4'hF, l1);
            end
        join
        check("t2_order", 32'(ack_code), 32'd12);
        check("t2_gap_count", 32'(gap_log.size()), 32'd2);
        check("t2_idle_gap", 32'(gap_log.size() > 0 ? gap_log[$] : -1), 32'd2);

        // Burst of three strobes from master 1 keeps the grant.
        ack_code = 0;
        fork
            begin
                int l1;
                run_cycle(1, 3, 32'h0000_0100, 1'b0, 32'd0, 4'hF, l1);
            end
            begin
                int l0;
                repeat (3) @(posedge clk);
                run_cycle(0, 1, 32'h0000_0200, 1'b1, 32'h2222_0000, 4'h3, l0);
            end
        join
        check("t3_order", 32'(ack_code), 32'd2221);

        // Master 0 back-to-back, master 1 once: no starvation.
        ack_code = 0;
        fork
            begin
                int l0;
                run_cycle(0, 1, 32'h0000_0300, 1'b0, 32'd0, 4'hF, l0);
                run_cycle(0, 1, 32'h0000_0304, 1'b0, 32'd0, 4'hF, l0);
            end
            begin
                int l1;
                repeat (2) @(posedge clk);
                run_cycle(1, 1, 32'h0000_0300, 1'b1, 32'h3333_3333, 4'hC, l1);
            end
        join
        check("t4_order", 32'(ack_code), 32'd121);

        // Master 1 writes the output port.
        ack_code = 0;
        run_cycle(1, 1, IO_PORT_ADR, 1'b1, 32'h0000_002A, 4'hF, lat);
        check("t5_order", 32'(ack_code), 32'd2);
        check("t5_io_value", slv_rd(IO_PORT_ADR), 32'h0000_002A);

        // Stalled slave: watchdog error (macro) or no error at all.
        stall = 1'b1;
        @(posedge clk); #1;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        m_we[0]  = 1'b0;
        m_adr[0] = 32'h0000_0400;
        first      = -1;
        err_at     = -1;
        err_cnt    = 0;
        stb_at_err = 1'b1;
        err_after  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (first < 0 && o_wb_stb) first = k;
            if (err_at >= 0 && k == err_at + 1) err_after = o_m_err[0];
            if (o_m_err[0]) begin
                err_cnt++;
                if (err_at < 0) begin
                    err_at     = k;
                    stb_at_err = o_wb_stb;
                end
            end
        end
`ifdef A23_WB_ARB_TIMEOUT_EN
        check("wd_delay", 32'(err_at - first), 32'(TO - 1));
        check("wd_pulse_width", 32'(err_after), 32'd0);
        check("wd_stb_forced_low", 32'(stb_at_err), 32'd0);
`else
        check("wd_no_err", 32'(err_cnt), 32'd0);
        check("wd_stb_held", 32'(o_wb_stb), 32'd1);
`endif
        @(posedge clk); #1;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        @(posedge clk); #1;
        stall = 1'b0;

        // Randomized traffic from both masters.
        for (int it = 0; it < 40; it++) begin
            fork
                begin
                    if ($urandom_range(3, 0) != 0) begin
                        repeat ($urandom_range(2, 0)) @(posedge clk);
                        rand_cycle(0);
                    end
                end
                begin
                    if ($urandom_range(3, 0) != 0) begin
                        repeat ($urandom_range(2, 0)) @(posedge clk);
                        rand_cycle(1);
                    end
                end
            join
        end

        repeat (3) @(posedge clk);
        check("sb_drain_m0", 32'(exp_q[0].size()), 32'd0);
        check("sb_drain_m1", 32'(exp_q[1].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
